// File: rtl/shared_mem_ctrl.sv
// Shared 4096x8 memory serving NUM_CORES load/store requesters through a round-robin arbiter,
// plus a host write port that is accepted only while the controller is idle.
module shared_mem_ctrl #(
    parameter int NUM_CORES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CORES-1:0]    mem_req_ld,
    input  logic [NUM_CORES-1:0]    mem_req_st,
    input  logic [NUM_CORES*12-1:0] addr_flat,
    input  logic [NUM_CORES*8-1:0]  st_data_flat,
    input  logic                    host_we,
    input  logic [11:0]             host_addr,
    input  logic [7:0]              host_wdata,
    output logic [NUM_CORES-1:0]    val_data,
    output logic [7:0]              mem_dat,
    output logic                    host_ready
);
    localparam int GW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LD_RD  = 3'd1;
    localparam logic [2:0] LD_RSP = 3'd2;
    localparam logic [2:0] ST_ACK = 3'd3;
    localparam logic [2:0] ST_WR  = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [GW-1:0]        gnt_q, gnt_d;
    logic [GW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [11:0]          addr_q, addr_d;
    logic [NUM_CORES-1:0] val_data_q, val_data_d;
    logic [7:0]           mem_dat_q, mem_dat_d;

    logic [7:0]           mem [0:4095];

    logic [NUM_CORES-1:0] req;
    logic                 found;
    logic [GW-1:0]        pick, cand;
    logic [11:0]          pick_addr;
    logic                 pick_ld;
    logic [7:0]           st_sel;
    logic                 mem_we;
    logic [11:0]          mem_waddr;
    logic [7:0]           mem_wdata;

    assign req = mem_req_ld | mem_req_st;

    // Round-robin: first requester strictly after the last grant, wrapping modulo NUM_CORES.
    always_comb begin
        found = 1'b0;
        pick  = rr_ptr_q;
        cand  = '0;
        for (int k = 1; k <= NUM_CORES; k++) begin
            cand = GW'((int'(rr_ptr_q) + k) % NUM_CORES);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        pick_addr = '0;
        pick_ld   = 1'b0;
        st_sel    = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (GW'(i) == pick) begin
                pick_addr = addr_flat[i*12 +: 12];
                pick_ld   = mem_req_ld[i];
            end
            if (GW'(i) == gnt_q) st_sel = st_data_flat[i*8 +: 8];
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        rr_ptr_d   = rr_ptr_q;
        addr_d     = addr_q;
        val_data_d = '0;
        mem_dat_d  = mem_dat_q;
        mem_we     = 1'b0;
        mem_waddr  = addr_q;
        mem_wdata  = st_sel;
        case (state_q)
            IDLE: begin
                if (host_we) begin
                    mem_we    = 1'b1;
                    mem_waddr = host_addr;
                    mem_wdata = host_wdata;
                end else if (found) begin
                    gnt_d    = pick;
                    rr_ptr_d = pick;
                    addr_d   = pick_addr;
                    // A core holding both requests is served its load first.
                    if (pick_ld) begin
                        state_d = LD_RD;
                    end else begin
                        state_d    = ST_ACK;
                        val_data_d = NUM_CORES'(1) << pick;
                    end
                end
            end
            LD_RD: begin
                mem_dat_d  = mem[addr_q];
                val_data_d = NUM_CORES'(1) << gnt_q;
                state_d    = LD_RSP;
            end
            LD_RSP: state_d = IDLE;
            ST_ACK: state_d = ST_WR;
            ST_WR: begin
                mem_we  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            rr_ptr_q   <= GW'(NUM_CORES - 1);
            addr_q     <= '0;
            val_data_q <= '0;
            mem_dat_q  <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            rr_ptr_q   <= rr_ptr_d;
            addr_q     <= addr_d;
            val_data_q <= val_data_d;
            mem_dat_q  <= mem_dat_d;
        end
    end

    // Storage is never cleared; writes are blocked while reset is held.
    always_ff @(posedge clk) begin
        if (mem_we && reset) mem[mem_waddr] <= mem_wdata;
    end

    assign val_data   = val_data_q;
    assign mem_dat    = mem_dat_q;
    assign host_ready = (state_q == IDLE);

endmodule

// File: tb/tb_shared_mem_ctrl.sv
// Directed bench for shared_mem_ctrl: a vector table of host writes, loads and stores,
// then hand sequences for arbitration order, host contention, mid-store reset and ld+st overlap.
module tb_shared_mem_ctrl;
    localparam int N = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [N-1:0]     mem_req_ld = '0;
    logic [N-1:0]     mem_req_st = '0;
    logic [N*12-1:0]  addr_flat = '0;
    logic [N*8-1:0]   st_data_flat = '0;
    logic             host_we = 1'b0;
    logic [11:0]      host_addr = '0;
    logic [7:0]       host_wdata = '0;
    logic [N-1:0]     val_data;
    logic [7:0]       mem_dat;
    logic             host_ready;

    int total = 0;
    int bad = 0;
    logic [7:0] last_ld = 8'h00;

    typedef struct {
        int         op;     // 0 host write, 1 load, 2 store
        int         core;
        logic [11:0] addr;
        logic [7:0] data;
        int         lat;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl [10];

    shared_mem_ctrl #(.NUM_CORES(N)) dut (
        .clk(clk), .reset(reset),
        .mem_req_ld(mem_req_ld), .mem_req_st(mem_req_st),
        .addr_flat(addr_flat), .st_data_flat(st_data_flat),
        .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .val_data(val_data), .mem_dat(mem_dat), .host_ready(host_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic host_wr(input logic [11:0] a, input logic [7:0] d);
        host_we = 1'b1; host_addr = a; host_wdata = d;
        step();
        host_we = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(); step();
        reset = 1'b1;
        last_ld = 8'h00;
    endtask

    task automatic core_op(input string nm, input int c, input bit ld, input logic [11:0] a,
                           input logic [7:0] d, input int exp_lat, input logic [7:0] exp_d);
        int lat = 0;
        addr_flat[c*12 +: 12] = a;
        if (ld) mem_req_ld[c] = 1'b1; else mem_req_st[c] = 1'b1;
        while (val_data[c] !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        check({nm, " latency"}, lat, exp_lat);
        check({nm, " val onehot"}, {28'd0, val_data}, 32'd1 << c);
        mem_req_ld[c] = 1'b0;
        mem_req_st[c] = 1'b0;
        if (ld) begin
            check({nm, " mem_dat"}, {24'd0, mem_dat}, {24'd0, exp_d});
            last_ld = exp_d;
        end else begin
            st_data_flat[c*8 +: 8] = d;
        end
        step(); step();
        if (!ld) check({nm, " mem_dat held"}, {24'd0, mem_dat}, {24'd0, last_ld});
        check({nm, " back idle"}, {31'd0, host_ready}, 32'd1);
    endtask

    initial begin
        int exp_c [5];
        int exp_t [5];
        logic [7:0] exp_dd [5];
        int got_c [$];
        int got_t [$];
        bit re0;

        tbl[0] = '{0, 0, 12'h0A5, 8'h3C, 0, 8'h00};
        tbl[1] = '{1, 2, 12'h0A5, 8'h00, 2, 8'h3C};
        tbl[2] = '{0, 0, 12'h000, 8'h11, 0, 8'h00};
        tbl[3] = '{2, 1, 12'hFFF, 8'h7E, 1, 8'h00};
        tbl[4] = '{1, 3, 12'hFFF, 8'h00, 2, 8'h7E};
        tbl[5] = '{1, 0, 12'h000, 8'h00, 2, 8'h11};
        tbl[6] = '{0, 0, 12'h010, 8'h55, 0, 8'h00};
        tbl[7] = '{2, 0, 12'h123, 8'hA9, 1, 8'h00};
        tbl[8] = '{1, 2, 12'h123, 8'h00, 2, 8'hA9};
        tbl[9] = '{1, 1, 12'h010, 8'h00, 2, 8'h55};

        // reset state, sampled while reset is still held
        step(); step();
        check("rst val_data", {28'd0, val_data}, 32'd0);
        check("rst mem_dat", {24'd0, mem_dat}, 32'd0);
        check("rst host_ready", {31'd0, host_ready}, 32'd1);
        reset = 1'b1;
        step();

        for (int i = 0; i < 10; i++) begin
            if (tbl[i].op == 0) begin
                host_wr(tbl[i].addr, tbl[i].data);
                check($sformatf("v%0d host idle", i), {31'd0, host_ready}, 32'd1);
            end else begin
                core_op($sformatf("v%0d", i), tbl[i].core, tbl[i].op == 1,
                        tbl[i].addr, tbl[i].data, tbl[i].lat, tbl[i].exp);
            end
        end

        // all four cores load at once right after reset; core 0 re-requests immediately
        do_reset();
        for (int i = 0; i < N; i++) host_wr(12'h100 + 12'(i), 8'h10 + 8'(i));
        exp_c = '{0, 1, 2, 3, 0};
        exp_t = '{2, 5, 8, 11, 14};
        exp_dd = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h13};
        re0 = 1'b0;
        for (int i = 0; i < N; i++) begin
            addr_flat[i*12 +: 12] = 12'h100 + 12'(i);
            mem_req_ld[i] = 1'b1;
        end
        for (int t = 1; t <= 20; t++) begin
            step();
            check("rr onehot", {31'd0, $countones(val_data) <= 1}, 32'd1);
            for (int i = 0; i < N; i++) begin
                if (val_data[i]) begin
                    if (got_c.size() < 5)
                        check("rr data", {24'd0, mem_dat}, {24'd0, exp_dd[got_c.size()]});
                    got_c.push_back(i);
                    got_t.push_back(t);
                    mem_req_ld[i] = 1'b0;
                    if (i == 0 && !re0) begin
                        re0 = 1'b1;
                        addr_flat[11:0] = 12'h103;
                        mem_req_ld[0] = 1'b1;
                    end
                end
            end
        end
        mem_req_ld = '0;
        check("rr grant count", got_c.size(), 5);
        for (int k = 0; k < 5 && k < got_c.size(); k++) begin
            check($sformatf("rr core #%0d", k), got_c[k], exp_c[k]);
            check($sformatf("rr cycle #%0d", k), got_t[k], exp_t[k]);
        end
        last_ld = 8'h13;

        // host write and core 0 load in the same idle cycle
        host_we = 1'b1; host_addr = 12'h200; host_wdata = 8'hC3;
        addr_flat[11:0] = 12'h200;
        mem_req_ld[0] = 1'b1;
        step();
        host_we = 1'b0;
        check("hc ready after host wr", {31'd0, host_ready}, 32'd1);
        check("hc no val yet", {28'd0, val_data}, 32'd0);
        step();
        check("hc ready low", {31'd0, host_ready}, 32'd0);
        check("hc val t2", {28'd0, val_data}, 32'd0);
        step();
        check("hc val t3", {28'd0, val_data}, 32'd1);
        check("hc data", {24'd0, mem_dat}, 32'hC3);
        mem_req_ld[0] = 1'b0;
        last_ld = 8'hC3;
        step(); step();

        // reset during ST_ACK of a store to 0x010
        addr_flat[12 +: 12] = 12'h010;
        mem_req_st[1] = 1'b1;
        step();
        check("rs ack", {28'd0, val_data}, 32'd2);
        st_data_flat[8 +: 8] = 8'hEE;
        #1 reset = 1'b0;
        #1;
        check("rs val async clear", {28'd0, val_data}, 32'd0);
        check("rs mem_dat clear", {24'd0, mem_dat}, 32'd0);
        mem_req_st[1] = 1'b0;
        #3 reset = 1'b1;
        last_ld = 8'h00;
        step(); step();
        core_op("rs reload", 2, 1'b1, 12'h010, 8'h00, 2, 8'h55);

        // core 2 holds load and store together: load first, store on next grant
        host_wr(12'h300, 8'h5A);
        addr_flat[24 +: 12] = 12'h300;
        mem_req_ld[2] = 1'b1;
        mem_req_st[2] = 1'b1;
        step();
        check("ls t1", {28'd0, val_data}, 32'd0);
        step();
        check("ls ld val", {28'd0, val_data}, 32'd4);
        check("ls ld data", {24'd0, mem_dat}, 32'h5A);
        mem_req_ld[2] = 1'b0;
        step();
        check("ls t3", {28'd0, val_data}, 32'd0);
        step();
        check("ls st val", {28'd0, val_data}, 32'd4);
        st_data_flat[16 +: 8] = 8'h77;
        mem_req_st[2] = 1'b0;
        step(); step();
        check("ls mem_dat held", {24'd0, mem_dat}, 32'h5A);
        last_ld = 8'h5A;
        core_op("ls readback", 2, 1'b1, 12'h300, 8'h00, 2, 8'h77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shared_mem_ctrl.md
# shared_mem_ctrl

Shared-memory responder for the GPU cluster: a 4096 x 8-bit on-chip memory that serves the load/store request interface of NUM_CORES gpu cores. It arbitrates round-robin between cores, answers each request with a one-cycle `val_data` pulse, and returns load data on a shared bus. A host write port preloads and patches memory contents between kernels.

## Interface
- NUM_CORES, 4: number of attached cores (1..16).
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low; clears all control state.
- mem_req_ld  in  NUM_CORES  per-core load request; held high until the core sees its `val_data`.
- mem_req_st  in  NUM_CORES  per-core store request; same hold rule.
- addr_flat  in  NUM_CORES*12  per-core address; core i uses bits [12i+11:12i]; stable while the request is high.
- st_data_flat  in  NUM_CORES*8  per-core store data; core i uses bits [8i+7:8i]; valid in the cycle after its `val_data` pulse.
- host_we  in  1  host write strobe.
- host_addr  in  12  host write address.
- host_wdata  in  8  host write data.
- val_data  out  NUM_CORES  per-core one-cycle completion pulse; registered.
- mem_dat  out  8  load data, broadcast to all cores; valid while the addressed core's `val_data` bit is high; registered.
- host_ready  out  1  high when `state == IDLE`; a `host_we` is accepted only in that cycle.

## Operation
- States: IDLE, LD_RD, LD_RSP, ST_ACK, ST_WR. Reset state: IDLE.
- IDLE:
  - If `host_we`: write `mem[host_addr] <= host_wdata`. No core is granted that cycle.
  - Otherwise, form `req[i] = mem_req_ld[i] | mem_req_st[i]`. Grant the first requesting core searching from `rr_ptr+1` upward, modulo NUM_CORES.
  - On a grant: latch the core index into `gnt`, latch its address into `addr_q`, and set `rr_ptr <= gnt`.
  - Go to LD_RD if that core's `mem_req_ld` is high, else ST_ACK. If both are high, the load wins and the store is served on a later grant.
- LD_RD: synchronous read of `mem[addr_q]`. At the edge, `mem_dat <=` the read data and `val_data[gnt] <= 1`. Go to LD_RSP.
- LD_RSP: `val_data[gnt]` is high for this cycle only; clear it at the edge. Go to IDLE.
- ST_ACK: `val_data[gnt]` is high for this cycle (set at the grant edge); clear it at the edge. Go to ST_WR.
- ST_WR: sample the granted core's slice of `st_data_flat`; write `mem[addr_q]` with it. Go to IDLE.
- `mem_dat` holds its last load value outside LD_RSP. Stores never change `mem_dat`.
- At most one `val_data` bit is ever high.
- Addresses are 12-bit and fully decoded; 0xFFF is a valid location with no wrap logic. Memory contents are not cleared by reset.
- `rr_ptr` resets to NUM_CORES-1, so core 0 has first priority after reset.
- Reset is asynchronous and may land in any state:
  - `val_data`, `mem_dat`, `gnt`, `addr_q` and `rr_ptr` clear immediately; the state returns to IDLE.
  - A store interrupted before ST_WR does not write memory.

## Timing
- The core's request is first visible in IDLE cycle T0.
- Load: LD_RD in T1; `val_data` and `mem_dat` high/valid in T2; the block is back in IDLE at T3. Three cycles per load.
- Store: `val_data` high in T1; data sampled and written at the end of T2; back in IDLE at T3. Three cycles per store.
- The core drops its request at the edge ending its `val_data` cycle, so the returning IDLE never sees a stale request from it.
- A host write in IDLE delays any pending grant by exactly one cycle.
- Worst-case wait for a request is NUM_CORES*3 cycles, plus any host writes.
- Memory write-to-read: a load granted the cycle after ST_WR returns the new data.

## Test plan
- Host writes 0x0A5 <- 0x3C; core 2 asserts `mem_req_ld` with addr 0x0A5 -> `val_data[2]` is high for exactly one cycle, two cycles after the request, with `mem_dat` = 0x3C; no other `val_data` bit toggles.
- Core 1 stores 0x7E to 0xFFF (data driven the cycle after `val_data[1]`), then core 3 loads 0xFFF -> `mem_dat` = 0x7E. Address 0x000 is unaffected.
- All four cores assert loads in the same cycle right after reset -> grants in order 0, 1, 2, 3, at three-cycle spacing. Core 0 re-requesting immediately is served after core 3.
- `host_we` and a core 0 request arrive in the same IDLE cycle -> host write happens first, `host_ready` drops the next cycle, and `val_data[0]` arrives one cycle later than the uncontended case.
- `reset` is pulled low during ST_ACK of a store to 0x010 (prior content 0x55) -> `val_data` clears in the same cycle without waiting for the clock; after release, a load of 0x010 returns 0x55.
- Core 2 asserts both `mem_req_ld` and `mem_req_st` -> the load is served first (LD_RD path); the store completes on the next grant to core 2.
